// File: rtl/eth_tx_fcs_insert.sv
// Ethernet transmit framer: passes the frame through, zero-pads short frames
// to MIN_BYTES and appends the FCS produced by an external CRC-32 engine.
module eth_tx_fcs_insert #(
    parameter int MIN_BYTES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [7:0]  crc_byte,
    output logic        crc_en,
    output logic        crc_eof,
    output logic        crc_reset,
    input  logic [31:0] crc_in
);

    typedef enum logic [1:0] {INIT, DATA, PAD, FCS} state_t;

    localparam logic [16:0] MIN_CNT = 17'(MIN_BYTES);

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;
    logic [1:0]  index_reg, index_next;
    logic [31:0] fcs_reg, fcs_next;

    logic        xfer;
    logic [16:0] count_inc;
    logic [15:0] count_sat;

    assign xfer      = m_axis_tvalid && m_axis_tready;
    assign count_inc = {1'b0, count_reg} + 17'd1;
    assign count_sat = (count_reg == 16'hFFFF) ? count_reg : count_inc[15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= INIT;
            count_reg <= '0;
            index_reg <= '0;
            fcs_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            index_reg <= index_next;
            fcs_reg   <= fcs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        fcs_next   = fcs_reg;
        case (state_reg)
            INIT: begin
                state_next = DATA;
                count_next = '0;
                index_next = '0;
            end
            DATA: begin
                if (xfer) begin
                    count_next = count_sat;
                    if (s_axis_tlast)
                        state_next = (count_inc < MIN_CNT) ? PAD : FCS;
                end
            end
            PAD: begin
                if (xfer) begin
                    count_next = count_sat;
                    if (count_inc >= MIN_CNT)
                        state_next = FCS;
                end
            end
            FCS: begin
                // Byte 0 goes straight out of the engine; keep the rest for indices 1..3.
                if (index_reg == 2'd0)
                    fcs_next = crc_in;
                if (xfer) begin
                    index_next = index_reg + 2'd1;
                    if (index_reg == 2'd3)
                        state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        crc_byte      = 8'h00;
        crc_en        = 1'b0;
        crc_eof       = 1'b0;
        crc_reset     = 1'b0;
        case (state_reg)
            INIT: begin
                crc_reset = 1'b1;
            end
            DATA: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                crc_byte      = s_axis_tdata;
                crc_en        = s_axis_tvalid && m_axis_tready;
            end
            PAD: begin
                m_axis_tvalid = 1'b1;
                crc_en        = m_axis_tready;
            end
            FCS: begin
                crc_eof       = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (index_reg == 2'd3);
                case (index_reg)
                    2'd0:    m_axis_tdata = crc_in[7:0];
                    2'd1:    m_axis_tdata = fcs_reg[15:8];
                    2'd2:    m_axis_tdata = fcs_reg[23:16];
                    default: m_axis_tdata = fcs_reg[31:24];
                endcase
            end
            default: crc_reset = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_fcs_insert.sv
// Bench for eth_tx_fcs_insert: two instances (MIN_BYTES 9 and 60), each with a
// reflected CRC-32 engine model; output streams are checked against a frame model.
module tb_eth_tx_fcs_insert;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [1:0][7:0]  s_tdata;
    logic [1:0]       s_tvalid;
    logic [1:0]       s_tlast;
    logic [1:0]       m_tready;
    wire  [1:0]       s_tready;
    wire  [1:0]       m_tvalid;
    wire  [1:0]       m_tlast;
    wire  [1:0][7:0]  m_tdata;
    wire  [1:0][7:0]  crc_byte;
    wire  [1:0]       crc_en;
    wire  [1:0]       crc_eof;
    wire  [1:0]       crc_reset;
    wire  [1:0][31:0] crc_in;

    int         n_checks = 0;
    int         n_errors = 0;
    int         frames_done = 0;
    int         act = 0;
    bit         stall_en = 1'b0;
    logic [8:0] out_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] tx_buf[128];

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] crc_state;
        always @(posedge clk) begin
            if (crc_reset[gi])
                crc_state <= 32'hFFFFFFFF;
            else if (crc_en[gi])
                crc_state <= crc_step(crc_state, crc_byte[gi]);
        end
        assign crc_in[gi] = crc_eof[gi] ? ~crc_state : crc_state;

        eth_tx_fcs_insert #(.MIN_BYTES(gi == 0 ? 9 : 60)) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .s_axis_tdata  (s_tdata[gi]),
            .s_axis_tvalid (s_tvalid[gi]),
            .s_axis_tlast  (s_tlast[gi]),
            .s_axis_tready (s_tready[gi]),
            .m_axis_tdata  (m_tdata[gi]),
            .m_axis_tvalid (m_tvalid[gi]),
            .m_axis_tlast  (m_tlast[gi]),
            .m_axis_tready (m_tready[gi]),
            .crc_byte      (crc_byte[gi]),
            .crc_en        (crc_en[gi]),
            .crc_eof       (crc_eof[gi]),
            .crc_reset     (crc_reset[gi]),
            .crc_in        (crc_in[gi])
        );
    end

    initial begin
        m_tready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_en ? 2'($urandom_range(0, 3)) : 2'b11;
        end
    end

    always @(negedge clk) begin
        if (reset_n && m_tvalid[act] && m_tready[act]) begin
            out_q.push_back({m_tlast[act], m_tdata[act]});
            if (m_tlast[act])
                frames_done++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    task automatic expect_frame(input int len, input int min_len);
        logic [31:0] c;
        logic [7:0]  b;
        int          tot;
        c   = 32'hFFFFFFFF;
        tot = (len < min_len) ? min_len : len;
        for (int i = 0; i < tot; i++) begin
            b = (i < len) ? tx_buf[i] : 8'h00;
            c = crc_step(c, b);
            exp_q.push_back({1'b0, b});
        end
        c = ~c;
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b1, c[31:24]});
    endtask

    task automatic send_frame(input int k, input int len, input bit gaps);
        int t;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid[k] = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata[k]  = tx_buf[i];
            s_tvalid[k] = 1'b1;
            s_tlast[k]  = (i == len - 1);
            t = 0;
            @(negedge clk);
            while (!s_tready[k] && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!s_tready[k]) begin
                check("upstream_handshake_timeout", 32'(t), 32'd0);
                s_tvalid[k] = 1'b0;
                s_tlast[k]  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int c;
        c = 0;
        while (frames_done < target && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        check(tag, 32'(frames_done), 32'(target));
    endtask

    task automatic compare_stream(input string tag);
        int n;
        int mism;
        check({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        n    = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        mism = 0;
        for (int i = 0; i < n; i++)
            if (out_q[i] !== exp_q[i])
                mism++;
        check({tag, "_bytes"}, 32'(mism), 32'd0);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        string s;
        int    len;
        int    z;

        reset_n  = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_crc_reset", 32'(crc_reset), 32'd3);
        check("rst_crc_en", 32'(crc_en), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("init_s_tready", 32'(s_tready), 32'd0);
        check("init_crc_reset", 32'(crc_reset), 32'd3);
        @(negedge clk);
        check("data_s_tready", 32'(s_tready), 32'd3);
        check("data_crc_reset", 32'(crc_reset), 32'd0);
        @(posedge clk);
        #1;

        // "123456789" through the MIN_BYTES=9 instance: check value CBF43926.
        act = 0;
        s   = "123456789";
        for (int i = 0; i < 9; i++) tx_buf[i] = s[i];
        expect_frame(9, 9);
        send_frame(0, 9, 1'b0);
        check("t1_fcs0_valid_next_cycle", 32'(m_tvalid[0]), 32'd1);
        check("t1_fcs0_direct", 32'(m_tdata[0]), 32'h26);
        wait_frames("t1_frames", 1, 200);
        @(negedge clk);
        check("t1_init_s_tready", 32'(s_tready[0]), 32'd0);
        check("t1_init_crc_reset", 32'(crc_reset[0]), 32'd1);
        check("t1_init_m_tvalid", 32'(m_tvalid[0]), 32'd0);
        check("t1_len", 32'(out_q.size()), 32'd13);
        check("t1_byte0", 32'(out_q[0]), 32'h031);
        check("t1_fcs0", 32'(out_q[9]), 32'h026);
        check("t1_fcs1", 32'(out_q[10]), 32'h039);
        check("t1_fcs2", 32'(out_q[11]), 32'h0F4);
        check("t1_fcs3_last", 32'(out_q[12]), 32'h1CB);
        compare_stream("t1");
        @(posedge clk);
        #1;

        // 14-byte frame padded to 60.
        act = 1;
        for (int i = 0; i < 14; i++) tx_buf[i] = 8'($urandom);
        expect_frame(14, 60);
        send_frame(1, 14, 1'b0);
        wait_frames("t2_frames", 2, 500);
        check("t2_len", 32'(out_q.size()), 32'd64);
        z = 0;
        for (int i = 14; i < 60; i++) if (out_q[i] === 9'h000) z++;
        check("t2_pad_zeros", 32'(z), 32'd46);
        compare_stream("t2");

        // 64-byte frame: no padding.
        for (int i = 0; i < 64; i++) tx_buf[i] = 8'($urandom);
        expect_frame(64, 60);
        send_frame(1, 64, 1'b0);
        wait_frames("t3_frames", 3, 500);
        check("t3_len", 32'(out_q.size()), 32'd68);
        check("t3_last_flag", 32'(out_q[67][8]), 32'd1);
        compare_stream("t3");

        // 100 back-to-back frames with random downstream stalls and upstream gaps.
        stall_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) tx_buf[i] = 8'($urandom);
            expect_frame(len, 60);
            send_frame(1, len, 1'b1);
        end
        wait_frames("t4_frames", 103, 60000);
        stall_en = 1'b0;
        compare_stream("t4");
        @(posedge clk);
        #1;

        // Reset during padding abandons the frame; the next frame must be clean.
        for (int i = 0; i < 14; i++) tx_buf[i] = 8'($urandom);
        send_frame(1, 14, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_m_tvalid", 32'(m_tvalid[1]), 32'd0);
        check("t5_rst_s_tready", 32'(s_tready[1]), 32'd0);
        check("t5_rst_crc_reset", 32'(crc_reset[1]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("t5_no_tlast_abandoned", 32'(frames_done), 32'd103);
        out_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) tx_buf[i] = 8'($urandom);
        expect_frame(20, 60);
        send_frame(1, 20, 1'b0);
        wait_frames("t5_frames", 104, 500);
        check("t5_len", 32'(out_q.size()), 32'd64);
        compare_stream("t5");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_fcs_insert.md
ETH_TX_FCS_INSERT -- requirements
Module: eth_tx_fcs_insert

Interface
REQ-001 SHALL have parameter MIN_BYTES, default 60, meaning minimum frame length in bytes before FCS (payload plus padding).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port s_axis_tdata  input  8  upstream frame byte (destination MAC first, no FCS).
REQ-005 SHALL have ports s_axis_tvalid input 1, s_axis_tlast input 1, s_axis_tready output 1  upstream AXI-Stream handshake.
REQ-006 SHALL have port m_axis_tdata  output  8  downstream byte (frame, pad, FCS).
REQ-007 SHALL have ports m_axis_tvalid output 1, m_axis_tlast output 1, m_axis_tready input 1  downstream AXI-Stream handshake.
REQ-008 SHALL have port crc_byte  output  8  byte presented to the external crc32 engine.
REQ-009 SHALL have ports crc_en output 1, crc_eof output 1, crc_reset output 1  crc32 enable, end-of-frame select, active-high synchronous init.
REQ-010 SHALL have port crc_in  input  32  crc32 engine output (final FCS while crc_eof=1).

Function
REQ-011 SHALL implement states INIT, DATA, PAD, FCS.
REQ-012 INIT: crc_reset=1, s_axis_tready=0, m_axis_tvalid=0; exits to DATA after exactly one cycle; byte counter cleared.
REQ-013 DATA: combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tlast=0.
REQ-014 Handshake = tvalid&&tready on the respective side; crc_en=1 and crc_byte=transferred byte exactly in handshake cycles in DATA and PAD, otherwise crc_en=0.
REQ-015 Byte counter (16 bit) increments per DATA/PAD handshake, saturates at 65535.
REQ-016 On DATA handshake with s_axis_tlast=1: next state PAD if counter+1 < MIN_BYTES, else FCS.
REQ-017 PAD: s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=8'h00; after handshake bringing counter to MIN_BYTES, next state FCS.
REQ-018 FCS: crc_eof=1, crc_en=0, s_axis_tready=0, m_axis_tvalid=1; 2-bit index selects byte.
REQ-019 FCS index 0 drives crc_in[7:0] directly and latches crc_in into fcs_reg on first FCS cycle; indices 1..3 drive fcs_reg[15:8], [23:16], [31:24].
REQ-020 m_axis_tlast=1 only on FCS index 3; its handshake returns to INIT.
REQ-021 Downstream stall (m_axis_tready=0) SHALL hold m_axis_tdata/tvalid/tlast and all state stable in every state.
REQ-022 Latency: zero cycles in DATA; FCS byte 0 valid the cycle after final data/pad handshake.
REQ-023 Frames of MIN_BYTES or more SHALL receive no padding; total output length = max(len, MIN_BYTES)+4.
REQ-024 Upstream tvalid dropping mid-frame SHALL insert idle cycles without crc_en and without output.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state INIT, counter 0, index 0, fcs_reg 0, m_axis_tvalid=0, s_axis_tready=0, crc_reset=1.
REQ-026 Reset mid-frame SHALL abandon the frame; no tlast is emitted for it; first frame after release begins one INIT cycle later.

Verification
REQ-027 MIN_BYTES=9, send ASCII "123456789" one frame -> output 9 bytes then 0x26,0x39,0xF4,0xCB, tlast on 0xCB.
REQ-028 MIN_BYTES=60, 14-byte frame -> 46 bytes 0x00 appended, 64 output bytes, FCS matches bench CRC-32 model of 60 bytes.
REQ-029 64-byte frame -> no padding, 68 output bytes, FCS matches model.
REQ-030 Random m_axis_tready (50%) and s_axis_tvalid gaps over 100 back-to-back frames -> byte stream and FCS identical to unstalled run, one INIT cycle between frames.
REQ-031 Assert reset_n low during PAD of frame 1 -> outputs idle immediately; frame 2 after release has correct FCS (crc re-initialised to 0xFFFFFFFF).
